// File: rtl/pulse_peak_capture.sv
// Gated peak/width capture of ADC pulses, one event per gate fall on an AXI-Stream master.
// Define PULSE_TIMESTAMP_EN to append a 32-bit rising-edge timestamp beat to every event.
module pulse_peak_capture #(
    parameter int ADC_WIDTH        = 14,
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int MIN_WIDTH        = 4
) (
    input  logic                        adc_clk,
    input  logic                        rst,
    input  logic [AXIS_TDATA_WIDTH-1:0] adc_dat_a,
    input  logic                        vgl,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic                        m_axis_tlast,
    input  logic                        m_axis_tready,
    output logic [15:0]                 evt_cnt,
    output logic [15:0]                 drop_cnt
);

    typedef enum logic {
        IDLE,
        TRACK
    } state_t;

    localparam logic [15:0] MIN_W = 16'(MIN_WIDTH);

    state_t                       state, state_nxt;
    logic signed [ADC_WIDTH-1:0]  data_d;
    logic signed [ADC_WIDTH-1:0]  peak;
    logic signed [15:0]           peak_ext;
    logic [15:0]                  width;
    logic                         vgl_d;
    logic                         buf_free;
    logic                         start;
    logic                         track;
    logic                         load;
    logic                         drop;

`ifdef PULSE_TIMESTAMP_EN
    logic [31:0] ts;
    logic [31:0] ts_lat;
    logic [31:0] ts_buf;
`endif

    assign peak_ext = 16'(peak);
    // A retiring tlast beat frees the slot in the same cycle, allowing back-to-back events.
    assign buf_free = ~m_axis_tvalid | (m_axis_tready & m_axis_tlast);

    always_ff @(posedge adc_clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        track     = 1'b0;
        load      = 1'b0;
        drop      = 1'b0;
        case (state)
            IDLE: begin
                if (vgl & ~vgl_d) begin
                    state_nxt = TRACK;
                    start     = 1'b1;
                end
            end
            TRACK: begin
                if (vgl) begin
                    track = 1'b1;
                end else begin
                    state_nxt = IDLE;
                    if (width >= MIN_W) begin
                        if (buf_free) load = 1'b1;
                        else          drop = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge adc_clk) begin
        if (rst) begin
            data_d        <= '0;
            vgl_d         <= 1'b1;
            peak          <= '0;
            width         <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            evt_cnt       <= '0;
            drop_cnt      <= '0;
        end else begin
            data_d <= adc_dat_a[ADC_WIDTH-1:0];
            vgl_d  <= vgl;

            if (start) begin
                peak  <= data_d;
                width <= 16'd1;
            end else if (track) begin
                if (data_d > peak) peak <= data_d;
                if (width != '1)   width <= width + 16'd1;
            end

            if (drop) drop_cnt <= drop_cnt + 16'd1;

            if (load) begin
                m_axis_tdata  <= {width, peak_ext};
                m_axis_tvalid <= 1'b1;
                evt_cnt       <= evt_cnt + 16'd1;
`ifdef PULSE_TIMESTAMP_EN
                m_axis_tlast  <= 1'b0;
`else
                m_axis_tlast  <= 1'b1;
`endif
            end else if (m_axis_tvalid & m_axis_tready) begin
                if (m_axis_tlast) begin
                    m_axis_tvalid <= 1'b0;
                end else begin
`ifdef PULSE_TIMESTAMP_EN
                    m_axis_tdata <= ts_buf;
`endif
                    m_axis_tlast <= 1'b1;
                end
            end
        end
    end

`ifdef PULSE_TIMESTAMP_EN
    always_ff @(posedge adc_clk) begin
        if (rst) begin
            ts     <= '0;
            ts_lat <= '0;
            ts_buf <= '0;
        end else begin
            ts <= ts + 32'd1;
            if (start) ts_lat <= ts;
            if (load)  ts_buf <= ts_lat;
        end
    end
`endif

endmodule

// File: tb/tb_pulse_peak_capture.sv
// Randomized and directed bench for pulse_peak_capture against a queue-based event model.
module tb_pulse_peak_capture;

    logic        adc_clk = 1'b0;
    logic        rst;
    logic [31:0] adc_dat_a;
    logic        vgl;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic [15:0] evt_cnt;
    logic [15:0] drop_cnt;

    int errs   = 0;
    int checks = 0;

    pulse_peak_capture #(
        .ADC_WIDTH       (14),
        .AXIS_TDATA_WIDTH(32),
        .MIN_WIDTH       (4)
    ) dut (
        .adc_clk      (adc_clk),
        .rst          (rst),
        .adc_dat_a    (adc_dat_a),
        .vgl          (vgl),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .evt_cnt      (evt_cnt),
        .drop_cnt     (drop_cnt)
    );

    always #5 adc_clk = ~adc_clk;

    // Reference model: pending output beats {tlast,tdata}, samples of the open pulse, counters.
    logic [32:0] m_q[$];
    int          m_samp[$];
    int          m_evt, m_drop, m_dprev;
    bit          m_in, m_prev_g;
    int unsigned m_ts, m_ts_lat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int sx(input logic [31:0] v);
        logic signed [13:0] s;
        s = v[13:0];
        return int'(s);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_samp.delete();
        m_evt = 0; m_drop = 0; m_dprev = 0;
        m_in = 0; m_prev_g = 1; m_ts = 0; m_ts_lat = 0;
    endtask

    task automatic model_step(input bit g, input bit rdy, input logic [31:0] dat);
        bit          acc, free;
        int          w, pk;
        logic [15:0] p16, w16;
        acc  = (m_q.size() > 0) && rdy;
        free = (m_q.size() == 0) || (acc && m_q.size() == 1);
        if (acc) void'(m_q.pop_front());
        if (!m_in) begin
            if (g && !m_prev_g) begin
                m_in = 1;
                m_samp.delete();
                m_samp.push_back(m_dprev);
                m_ts_lat = m_ts;
            end
        end else if (g) begin
            m_samp.push_back(m_dprev);
        end else begin
            m_in = 0;
            w  = (m_samp.size() > 65535) ? 65535 : m_samp.size();
            pk = m_samp[0];
            for (int i = 1; i < m_samp.size(); i++) if (m_samp[i] > pk) pk = m_samp[i];
            if (w >= 4) begin
                if (free) begin
                    p16 = pk[15:0];
                    w16 = w[15:0];
`ifdef PULSE_TIMESTAMP_EN
                    m_q.push_back({1'b0, w16, p16});
                    m_q.push_back({1'b1, m_ts_lat});
`else
                    m_q.push_back({1'b1, w16, p16});
`endif
                    m_evt = (m_evt + 1) % 65536;
                end else begin
                    m_drop = (m_drop + 1) % 65536;
                end
            end
        end
        m_prev_g = g;
        m_dprev  = sx(dat);
        m_ts++;
    endtask

    // One clock: compare outputs of the previous edge, then drive inputs for the next edge.
    task automatic tick(input bit g, input logic [31:0] dat, input bit rdy, input bit r);
        @(negedge adc_clk);
        check("tvalid", 32'(m_axis_tvalid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            check("tdata", m_axis_tdata, m_q[0][31:0]);
            check("tlast", 32'(m_axis_tlast), 32'(m_q[0][32]));
        end
        check("evt_cnt", {16'd0, evt_cnt}, m_evt[31:0]);
        check("drop_cnt", {16'd0, drop_cnt}, m_drop[31:0]);
        vgl = g; adc_dat_a = dat; m_axis_tready = rdy; rst = r;
        if (r) model_reset();
        else   model_step(g, rdy, dat);
    endtask

    task automatic send_pulse(input int pat[$], input bit rdy);
        for (int k = 0; k <= pat.size(); k++)
            tick(k >= 1, (k < pat.size()) ? pat[k] : 0, rdy, 0);
        tick(0, 32'd0, rdy, 0);
    endtask

    task automatic after_edge();
        @(posedge adc_clk);
        #1;
    endtask

    localparam logic [31:0] LAST_BEAT0 =
`ifdef PULSE_TIMESTAMP_EN
        32'd0;
`else
        32'd1;
`endif

    initial begin
        bit          g;
        logic [31:0] d;
        rst = 1; vgl = 0; adc_dat_a = '0; m_axis_tready = 0;
        model_reset();
        repeat (2) @(posedge adc_clk);
        tick(0, 32'd0, 1, 1);
        tick(0, 32'd0, 1, 0);

        // Ramp pulse, width 10, peak 200
        send_pulse('{-5, 40, 90, 150, 200, 150, 90, 40, 10, -5}, 1);
        after_edge();
        check("t1_tdata", m_axis_tdata, 32'h000A_00C8);
        check("t1_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("t1_tlast", 32'(m_axis_tlast), LAST_BEAT0);
        check("t1_evt", {16'd0, evt_cnt}, 32'd1);
        repeat (3) tick(0, 32'd0, 1, 0);

        // Too short
        send_pulse('{100, 300, 200}, 1);
        after_edge();
        check("t2_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("t2_evt", {16'd0, evt_cnt}, 32'd1);
        check("t2_drop", {16'd0, drop_cnt}, 32'd0);

        // All-negative pulse
        send_pulse('{-300, -200, -100, -150, -250}, 1);
        after_edge();
        check("t3_tdata", m_axis_tdata, 32'h0005_FF9C);
        repeat (3) tick(0, 32'd0, 1, 0);

        // Backpressure: second event dropped, first held
        send_pulse('{10, 20, 30, 40, 50}, 0);
        send_pulse('{1000, 1000, 1000, 1000, 1000, 1000, 1000}, 0);
        after_edge();
        check("t4_tdata", m_axis_tdata, 32'h0005_0032);
        check("t4_drop", {16'd0, drop_cnt}, 32'd1);
        check("t4_evt", {16'd0, evt_cnt}, 32'd3);
        repeat (6) tick(0, 32'd0, 1, 0);

        // Saturating width, then reset mid-pulse
        tick(0, 32'd0, 1, 1);
        tick(0, 32'd0, 1, 0);
        for (int i = 0; i < 70000; i++) tick(1, $urandom, 1, 0);
        tick(0, 32'd0, 1, 0);
        after_edge();
        check("t5_width", {16'd0, m_axis_tdata[31:16]}, 32'h0000_FFFF);
        repeat (3) tick(0, 32'd0, 1, 0);
        for (int i = 0; i < 20; i++) tick(1, $urandom, 1, 0);
        tick(1, 32'd0, 1, 1);
        after_edge();
        check("t5_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("t5_rst_evt", {16'd0, evt_cnt}, 32'd0);
        for (int i = 0; i < 10; i++) tick(1, $urandom, 1, 0);
        tick(0, 32'd0, 1, 0);
        after_edge();
        check("t5_no_evt", {16'd0, evt_cnt}, 32'd0);
        send_pulse('{5, 6, 7, 8, 9, 4}, 1);
        after_edge();
        check("t5_rearm", {16'd0, evt_cnt}, 32'd1);

        // Random gate runs, data and backpressure, rare resets
        g = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 28) g = ~g;
            d = $urandom;
            tick(g, d, $urandom_range(0, 3) != 0, $urandom_range(0, 799) == 0);
        end
        repeat (4) tick(0, 32'd0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
